// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - handshake and serial-line bundle for serial_tx
//
// Purpose: groups the word handshake (DIN/LOAD/READY), the frame-complete
// pulse (DONE) and the serial line (Q) of the transmitter.
// Signals:
//   DIN    word to transmit, driven by the master
//   LOAD   frame request, driven by the master
//   READY  transmitter idle and able to accept LOAD
//   DONE   one-cycle pulse after the last stop-bit cycle
//   Q      registered serial line, idle level 1
// Modports: master = word source / line observer, slave = transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DIN;
  logic              LOAD;
  logic              READY;
  logic              DONE;
  logic              Q;

  modport master (output DIN, output LOAD, input READY, input DONE, input Q);
  modport slave  (input DIN, input LOAD, output READY, output DONE, output Q);
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parameterised parallel-to-serial framed transmitter
//
// Purpose: accepts a DATA_W-bit word on LOAD while READY and sends it on Q as
// start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
// Every bit is held for BIT_CYCLES clocks. All outputs are registered.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the parity bit
// (XOR of the data bits) between the last data bit and the stop bit.
// Ports:
//   CK    clock, rising edge
//   RST   synchronous active-high reset, overrides everything
//   bus   serial_tx_if slave modport (DIN, LOAD, READY, DONE, Q)
module serial_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 2
) (
  input  logic        CK,
  input  logic        RST,
  serial_tx_if.slave  bus
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              q_q, q_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              bit_end;
  logic              start_frame;
  logic [DATA_W-1:0] shift_nx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    q_d      = q_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d    = par_q;
`endif
    bit_end  = (cnt_q == CNT_W'(BIT_CYCLES - 1));
    shift_nx = shift_q >> 1;

    // A LOAD present on the final stop-bit edge chains straight into the
    // next start bit, so held LOAD yields gap-free frames.
    start_frame = bus.LOAD &&
                  (((state_q == S_IDLE) && ready_q) ||
                   ((state_q == S_STOP) && bit_end));

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        q_d     = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
      S_START: begin
        if (bit_end) begin
          q_d     = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            q_d     = par_q;
            state_d = S_PARITY;
`else
            q_d     = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_nx;
            q_d     = shift_nx[0];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          q_d     = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          q_d     = 1'b1;
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        q_d     = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    if (start_frame) begin
      shift_d = bus.DIN;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = ^bus.DIN;
`endif
      q_d     = 1'b0;
      ready_d = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.Q     = q_q;
  assign bus.READY = ready_q;
  assign bus.DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
module tb_serial_tx;

  localparam int BC = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + 8 + P;
  localparam int FL = NB * BC;

  logic CK;
  logic RST;
  int   vectors;
  int   errs;

  serial_tx_if #(.DATA_W(8)) bus ();

  serial_tx #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit b: start, data LSB first, parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((P == 1) && (b == 9)) return ^d;
    return 1'b1;
  endfunction

  task automatic idle_check(input string tag);
    check({tag, "_q"}, {7'd0, bus.Q}, 8'd1);
    check({tag, "_ready"}, {7'd0, bus.READY}, 8'd1);
    check({tag, "_done"}, {7'd0, bus.DONE}, 8'd0);
  endtask

  // Called at a negedge; LOAD is accepted at the following posedge.
  task automatic accept(input logic [7:0] d);
    bus.DIN  = d;
    bus.LOAD = 1'b1;
    @(posedge CK);
  endtask

  task automatic body(input logic [7:0] d, input int first_k, input bit chain,
                      input logic [7:0] d2, input int busy_k, input int abort_k);
    for (int k = first_k; k < FL; k++) begin
      @(negedge CK);
      check($sformatf("q_%02h_k%0d", d, k), {7'd0, bus.Q}, {7'd0, exp_bit(d, k / BC)});
      check($sformatf("ready_%02h_k%0d", d, k), {7'd0, bus.READY}, 8'd0);
      check($sformatf("done_%02h_k%0d", d, k), {7'd0, bus.DONE}, 8'd0);
      if (k == first_k) begin
        bus.LOAD = chain;
        bus.DIN  = chain ? d2 : ~d;
      end
      if (k == busy_k) begin
        bus.LOAD = 1'b1;
        bus.DIN  = 8'hFF;
      end
      if (k == busy_k + 1) bus.LOAD = 1'b0;
      if (k == abort_k) begin
        RST = 1'b1;
        @(negedge CK);
        idle_check("abort_edge");
        RST = 1'b0;
        @(negedge CK);
        idle_check("abort_after");
        return;
      end
    end
    @(negedge CK);
    check($sformatf("end_done_%02h", d), {7'd0, bus.DONE}, 8'd1);
    check($sformatf("end_ready_%02h", d), {7'd0, bus.READY}, {7'd0, ~chain});
    check($sformatf("end_q_%02h", d), {7'd0, bus.Q}, {7'd0, ~chain});
    if (!chain) begin
      @(negedge CK);
      idle_check($sformatf("post_%02h", d));
    end
  endtask

  initial begin
    vectors  = 0;
    errs     = 0;
    RST      = 1'b1;
    bus.LOAD = 1'b0;
    bus.DIN  = 8'h00;

    // Reset then idle
    repeat (2) begin
      @(negedge CK);
      idle_check("reset");
    end
    RST = 1'b0;
    repeat (10) begin
      @(negedge CK);
      idle_check("idle");
    end

    // Single frame
    accept(8'hA5);
    body(8'hA5, 0, 1'b0, 8'h00, -10, -10);

    // Parity polarity with a single set bit
    accept(8'h01);
    body(8'h01, 0, 1'b0, 8'h00, -10, -10);

    // LOAD while busy is ignored
    accept(8'h0F);
    body(8'h0F, 0, 1'b0, 8'h00, 7, -10);
    repeat (3) begin
      @(negedge CK);
      idle_check("busy_after");
    end

    // Back-to-back with LOAD held high
    accept(8'h3C);
    body(8'h3C, 0, 1'b1, 8'hC3, -10, -10);
    body(8'hC3, 1, 1'b0, 8'h00, -10, -10);

    // Reset during data bit 3
    accept(8'h55);
    body(8'h55, 0, 1'b0, 8'h00, -10, 8);
    accept(8'h81);
    body(8'h81, 0, 1'b0, 8'h00, -10, -10);

    // RST and LOAD together: reset wins
    bus.DIN  = 8'h99;
    bus.LOAD = 1'b1;
    RST      = 1'b1;
    @(negedge CK);
    idle_check("rst_load");
    bus.LOAD = 1'b0;
    RST      = 1'b0;
    @(negedge CK);
    idle_check("rst_load_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parameterised parallel-to-serial transmitter. Accepts a data word through a LOAD/READY handshake, then drives it onto a single registered line `Q` as a framed serial stream. The frame is a start bit, data bits LSB first, an optional parity bit and a stop bit. It is the sending end for a single-bit sampling receiver clocked on the same `CK`; each bit is held for a fixed number of clock cycles so the receiver can sample mid-bit.

## Interface
Parameters:
- `DATA_W`, 8, data word width in bits; must be ≥1.
- `BIT_CYCLES`, 2, clock cycles each serial bit is held on `Q`; must be ≥1.

Ports:
- `CK`  input  1  clock; all state updates on rising edge.
- `RST`  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `DIN`  input  DATA_W  word to transmit; sampled only on an accepted LOAD.
- `LOAD`  input  1  request to start a frame; accepted at a rising edge when READY=1.
- `READY`  output  1  high when idle and able to accept LOAD.
- `DONE`  output  1  one-cycle pulse after the last stop-bit cycle.
- `Q`  output  1  serial line, registered; idle level 1.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset values: Q=1, READY=1, DONE=0, state IDLE, counters 0, shift register 0.
- IDLE: Q=1, READY=1.
  - On an edge with LOAD=1, READY=1 and RST=0: capture DIN into the shift register, set Q←0, READY←0, and go to START.
- Bit timing: a cycle counter counts 0..BIT_CYCLES-1 and each state/bit lasts exactly BIT_CYCLES cycles. The counter clears on every bit transition.
- START → DATA: Q←shift[0].
- DATA: after each bit period, shift right and drive the next bit. After DATA_W bits, go to PARITY (Q←parity) or to STOP (Q←1).
- PARITY → STOP: Q←1.
- STOP: at the end of the period, go to IDLE with READY←1 and DONE←1 for exactly one cycle. Q stays 1.
- LOAD while READY=0: ignored. DIN is not sampled and there is no queuing.
- Back-to-back frames: if LOAD=1 in the cycle where READY rises (the DONE cycle), the next frame is accepted at that edge. Q then goes 1→0 with the stop bit lasting exactly BIT_CYCLES cycles; there is no extra idle cycle.
- DIN changing after acceptance has no effect on the frame in flight.

## Timing
- Latency: accepting edge → first start-bit cycle on Q is 0 cycles. Q changes on the accepting edge itself.
- Frame length, from accepting edge to the edge raising READY: (2+DATA_W+P)·BIT_CYCLES cycles. P=1 when the macro is defined, else 0.
- All outputs are registered. There is no combinational path from any input to Q, READY or DONE.
- RST=1 at any edge, including mid-frame, overrides everything: the frame is abandoned and all outputs take their reset values at that edge.
- RST and LOAD high together: RST wins and the frame is not accepted.
- A LOAD held high continuously produces contiguous frames.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state is present. One bit = XOR of the DATA_W captured bits (even parity: total ones in data+parity is even) is sent between the last data bit and the stop bit, for BIT_CYCLES cycles. Frame length includes P=1.
- Undefined: there is no PARITY state or logic, DATA goes directly to STOP, and P=0.

## Test plan
All scenarios use DATA_W=8, BIT_CYCLES=2.
- Reset then idle: RST high for 2 cycles, then low 10 cycles → Q=1, READY=1, DONE=0 throughout.
- Single frame, no parity: DIN=0xA5, LOAD for 1 cycle.
  - Q per 2-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - READY low for 20 cycles; DONE pulses once on the 21st cycle.
- Parity build: DIN=0xA5 (four ones) → parity bit 0 after bit7 and READY low for 22 cycles. Repeat with DIN=0x01 → parity bit 1.
- Busy LOAD ignored: send 0x0F, pulse LOAD with DIN=0xFF mid-frame → the transmitted bits remain those of 0x0F, and only one DONE.
- Back-to-back: hold LOAD high with DIN=0x3C then 0xC3 → the second start bit immediately follows a 2-cycle stop bit, with no idle gap. Both frames are bit-exact.
- Reset mid-frame: assert RST during data bit 3 of 0x55 → at that edge Q=1, READY=1, DONE=0. A new LOAD of 0x81 then sends a correct full frame.
